// File: rtl/picosoc_bus_pkg.sv
// Shared types and constants for the PicoRV32 native-bus arbiter.
package picosoc_bus_pkg;

    localparam int unsigned MAX_MASTERS = 4;
    localparam int unsigned ID_W        = $clog2(MAX_MASTERS);
    localparam int unsigned ADDR_W      = 32;
    localparam int unsigned DATA_W      = 32;
    localparam int unsigned STRB_W      = 4;

    localparam logic [DATA_W-1:0] ERR_RDATA_DEF = 32'hDEAD_BEEF;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } bus_state_e;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [STRB_W-1:0] wstrb;
    } bus_req_t;

    // Round-robin successor of a master index, wrapping at n.
    function automatic logic [ID_W-1:0] next_ptr(input logic [ID_W-1:0] id, input int unsigned n);
        if (32'(id) + 32'd1 >= n) return '0;
        return id + ID_W'(1);
    endfunction

endpackage

// File: rtl/picosoc_rr_pick.sv
// Combinational round-robin picker: first requester at or after ptr, cyclically.
module picosoc_rr_pick
    import picosoc_bus_pkg::*;
#(
    parameter int unsigned N = 2
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] ptr,
    output logic            any,
    output logic [ID_W-1:0] idx
);

    int unsigned cand;

    always_comb begin
        any  = 1'b0;
        idx  = '0;
        cand = 0;
        for (int unsigned i = 0; i < N; i++) begin
            cand = 32'(ptr) + i;
            if (cand >= N) cand = cand - N;
            if (!any && req[cand]) begin
                any = 1'b1;
                idx = ID_W'(cand);
            end
        end
    end

endmodule

// File: rtl/picosoc_bus_arbiter.sv
// Round-robin arbiter sharing one PicoRV32 native-bus slave port between
// several masters, with a bus-hang timeout and sticky error capture.
module picosoc_bus_arbiter
    import picosoc_bus_pkg::*;
#(
    parameter int unsigned NUM_MASTERS    = 2,
    parameter int unsigned TIMEOUT_CYCLES = 256,
    parameter logic [31:0] ERR_RDATA      = ERR_RDATA_DEF
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_MASTERS-1:0]    m_valid,
    output logic [NUM_MASTERS-1:0]    m_ready,
    input  logic [32*NUM_MASTERS-1:0] m_addr,
    input  logic [32*NUM_MASTERS-1:0] m_wdata,
    input  logic [4*NUM_MASTERS-1:0]  m_wstrb,
    output logic [31:0]               m_rdata,
    output logic                      s_valid,
    input  logic                      s_ready,
    output logic [31:0]               s_addr,
    output logic [31:0]               s_wdata,
    output logic [3:0]                s_wstrb,
    input  logic [31:0]               s_rdata,
    output logic [1:0]                grant_id,
    output logic                      err_sticky,
    output logic [31:0]               err_addr,
    input  logic                      err_clr
);

    localparam int unsigned N      = NUM_MASTERS;
    localparam int unsigned TW_RAW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned TW     = (TW_RAW < 8) ? 8 : ((TW_RAW > 16) ? 16 : TW_RAW);
    localparam bit          TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
    localparam logic [TW-1:0] TIMER_LAST = (TIMEOUT_CYCLES == 0) ? '0 : TW'(TIMEOUT_CYCLES - 1);

    bus_state_e      state;
    logic [ID_W-1:0] rr_ptr;
    logic [TW-1:0]   timer;
    bus_req_t        sel;
    logic            gnt_valid;
    logic            pick_any;
    logic [ID_W-1:0] pick_idx;
    logic            busy;
    logic            timeout_hit;
    logic            abandon;
    logic            done;
    logic            timeout_evt;

    picosoc_rr_pick #(.N(N)) u_pick (
        .req (m_valid),
        .ptr (rr_ptr),
        .any (pick_any),
        .idx (pick_idx)
    );

    // Request mux and granted-master valid, selected by grant_id.
    always_comb begin
        sel       = '0;
        gnt_valid = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            if (grant_id == ID_W'(i)) begin
                sel.addr  = m_addr[32*i +: 32];
                sel.wdata = m_wdata[32*i +: 32];
                sel.wstrb = m_wstrb[4*i +: 4];
                gnt_valid = m_valid[i];
            end
        end
    end

    assign busy        = (state == ST_BUSY);
    assign s_valid     = busy;
    assign s_addr      = sel.addr;
    assign s_wdata     = sel.wdata;
    assign s_wstrb     = sel.wstrb;
    assign timeout_hit = TIMEOUT_EN && busy && !s_ready && (timer == TIMER_LAST);
    // A master dropping its request abandons the transfer; that beats completion.
    assign abandon     = busy && !gnt_valid;
    assign done        = busy && !reset && !abandon && (s_ready || timeout_hit);
    assign timeout_evt = done && !s_ready;

    always_comb begin
        m_ready = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (done && grant_id == ID_W'(i)) m_ready[i] = 1'b1;
        end
        m_rdata = done ? (s_ready ? s_rdata : ERR_RDATA) : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            rr_ptr     <= '0;
            grant_id   <= '0;
            timer      <= '0;
            err_sticky <= 1'b0;
            err_addr   <= '0;
        end else begin
            // A timeout in the same cycle as err_clr keeps the error set.
            if (err_clr) err_sticky <= 1'b0;
            if (timeout_evt) begin
                err_sticky <= 1'b1;
                if (!err_sticky) err_addr <= s_addr;
            end
            case (state)
                ST_IDLE: begin
                    if (pick_any) begin
                        grant_id <= pick_idx;
                        timer    <= '0;
                        state    <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (abandon) begin
                        state <= ST_IDLE;
                    end else if (done) begin
                        state  <= ST_IDLE;
                        rr_ptr <= next_ptr(grant_id, N);
                    end else if (timer != '1) begin
                        timer <= timer + TW'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_picosoc_bus_arbiter.sv
// Directed self-checking bench for picosoc_bus_arbiter (2 masters, 16-cycle timeout).
module tb_picosoc_bus_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  m_valid;
    logic [1:0]  m_ready;
    logic [63:0] m_addr;
    logic [63:0] m_wdata;
    logic [7:0]  m_wstrb;
    logic [31:0] m_rdata;
    logic        s_valid;
    logic        s_ready;
    logic [31:0] s_addr;
    logic [31:0] s_wdata;
    logic [3:0]  s_wstrb;
    logic [31:0] s_rdata;
    logic [1:0]  grant_id;
    logic        err_sticky;
    logic [31:0] err_addr;
    logic        err_clr;

    int n_checks = 0;
    int n_errs   = 0;

    picosoc_bus_arbiter #(
        .NUM_MASTERS    (2),
        .TIMEOUT_CYCLES (16),
        .ERR_RDATA      (32'hDEAD_BEEF)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_addr     (m_addr),
        .m_wdata    (m_wdata),
        .m_wstrb    (m_wstrb),
        .m_rdata    (m_rdata),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_addr     (s_addr),
        .s_wdata    (s_wdata),
        .s_wstrb    (s_wstrb),
        .s_rdata    (s_rdata),
        .grant_id   (grant_id),
        .err_sticky (err_sticky),
        .err_addr   (err_addr),
        .err_clr    (err_clr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [1:0]  mv;
        logic [63:0] ma;
        logic [63:0] mw;
        logic [7:0]  ms;
        logic        sr;
        logic [31:0] srd;
        logic        chk_bus;
        logic        sv;
        logic [1:0]  mr;
        logic [31:0] rd;
        logic [1:0]  gid;
        logic [31:0] sa;
        logic [31:0] sw;
        logic [3:0]  ss;
    } vec_t;

    vec_t vt[11];

    function automatic vec_t mk(input logic rst, input logic [1:0] mv, input logic [63:0] ma,
                                input logic [63:0] mw, input logic [7:0] ms, input logic sr,
                                input logic [31:0] srd, input logic chk_bus, input logic sv,
                                input logic [1:0] mr, input logic [31:0] rd, input logic [1:0] gid,
                                input logic [31:0] sa, input logic [31:0] sw, input logic [3:0] ss);
        vec_t v;
        v.rst = rst; v.mv = mv; v.ma = ma; v.mw = mw; v.ms = ms; v.sr = sr; v.srd = srd;
        v.chk_bus = chk_bus; v.sv = sv; v.mr = mr; v.rd = rd; v.gid = gid;
        v.sa = sa; v.sw = sw; v.ss = ss;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Runs one transaction: s_ready rises on BUSY cycle ready_after+1 (never if 0);
    // optionally pulses err_clr on the 16th BUSY cycle. Returns at the m_ready cycle.
    task automatic run_txn(input int ready_after, input bit clr_at_16, output int busy_n,
                           output logic [1:0] mr, output logic [31:0] rd, output bit ok);
        busy_n = 0;
        mr     = '0;
        rd     = '0;
        ok     = 1'b0;
        for (int c = 0; c < 60 && !ok; c++) begin
            @(negedge clk);
            if (s_valid) busy_n++;
            s_ready = (ready_after > 0) && (busy_n == ready_after + 1);
            err_clr = clr_at_16 && (busy_n == 16);
            #1;
            if (m_ready != 2'b00) begin
                mr = m_ready;
                rd = m_rdata;
                ok = 1'b1;
            end
        end
        if (!ok) begin
            n_checks++;
            n_errs++;
            $display("FAIL run_txn: no m_ready within budget, got busy=%0d expected completion", busy_n);
        end
    endtask

    localparam logic [63:0] A0  = 64'h0000_0000_0000_0010;
    localparam logic [63:0] A1  = {32'h0200_0008, 32'h0};
    localparam logic [63:0] W1  = {32'h0000_0041, 32'h0};

    initial begin
        int          bn;
        logic [1:0]  mr;
        logic [31:0] rd;
        bit          ok;
        logic [1:0]  exp_g;

        reset = 1'b1; m_valid = '0; m_addr = '0; m_wdata = '0; m_wstrb = '0;
        s_ready = 1'b0; s_rdata = '0; err_clr = 1'b0;
        repeat (2) @(posedge clk);

        // rst mv  ma  mw  ms     sr  srd            bus sv mr     rd             gid  sa             sw     ss
        vt[0]  = mk(1, 2'b00, A0, '0, 8'h00, 0, 32'h0,        0, 0, 2'b00, 32'h0,        0, 32'h0,        32'h0, 4'h0);
        vt[1]  = mk(0, 2'b01, A0, '0, 8'h00, 0, 32'h0,        0, 0, 2'b00, 32'h0,        0, 32'h0,        32'h0, 4'h0);
        vt[2]  = mk(0, 2'b01, A0, '0, 8'h00, 0, 32'h0,        1, 1, 2'b00, 32'h0,        0, 32'h10,       32'h0, 4'h0);
        vt[3]  = mk(0, 2'b01, A0, '0, 8'h00, 0, 32'h0,        1, 1, 2'b00, 32'h0,        0, 32'h10,       32'h0, 4'h0);
        vt[4]  = mk(0, 2'b01, A0, '0, 8'h00, 0, 32'h0,        1, 1, 2'b00, 32'h0,        0, 32'h10,       32'h0, 4'h0);
        vt[5]  = mk(0, 2'b01, A0, '0, 8'h00, 1, 32'h1234_5678, 1, 1, 2'b01, 32'h1234_5678, 0, 32'h10,      32'h0, 4'h0);
        vt[6]  = mk(0, 2'b00, A0, '0, 8'h00, 1, 32'h1234_5678, 0, 0, 2'b00, 32'h0,        0, 32'h0,        32'h0, 4'h0);
        vt[7]  = mk(0, 2'b10, A1, W1, 8'h10, 0, 32'h0,        0, 0, 2'b00, 32'h0,        0, 32'h0,        32'h0, 4'h0);
        vt[8]  = mk(0, 2'b10, A1, W1, 8'h10, 0, 32'h0,        1, 1, 2'b00, 32'h0,        1, 32'h0200_0008, 32'h41, 4'h1);
        vt[9]  = mk(0, 2'b10, A1, W1, 8'h10, 1, 32'h55,       1, 1, 2'b10, 32'h55,       1, 32'h0200_0008, 32'h41, 4'h1);
        vt[10] = mk(0, 2'b00, A1, W1, 8'h10, 0, 32'h0,        0, 0, 2'b00, 32'h0,        1, 32'h0,        32'h0, 4'h0);

        // Single-cycle vectors: basic read, idle s_ready, m1 write mux.
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            reset = vt[i].rst; m_valid = vt[i].mv; m_addr = vt[i].ma; m_wdata = vt[i].mw;
            m_wstrb = vt[i].ms; s_ready = vt[i].sr; s_rdata = vt[i].srd;
            #1;
            chk($sformatf("r%0d s_valid", i), 32'(s_valid), 32'(vt[i].sv));
            chk($sformatf("r%0d m_ready", i), 32'(m_ready), 32'(vt[i].mr));
            chk($sformatf("r%0d m_rdata", i), m_rdata, vt[i].rd);
            chk($sformatf("r%0d grant_id", i), 32'(grant_id), 32'(vt[i].gid));
            chk($sformatf("r%0d err_sticky", i), 32'(err_sticky), 32'h0);
            chk($sformatf("r%0d err_addr", i), err_addr, 32'h0);
            if (vt[i].chk_bus) begin
                chk($sformatf("r%0d s_addr", i), s_addr, vt[i].sa);
                chk($sformatf("r%0d s_wdata", i), s_wdata, vt[i].sw);
                chk($sformatf("r%0d s_wstrb", i), 32'(s_wstrb), 32'(vt[i].ss));
            end
        end

        // Fairness: both masters request continuously, grants alternate from 0.
        m_valid = 2'b11; m_addr = {32'h2000, 32'h1000}; s_rdata = 32'hA5A5_0000;
        exp_g = 2'd0;
        for (int t = 0; t < 20; t++) begin
            run_txn(1, 1'b0, bn, mr, rd, ok);
            if (ok) begin
                chk($sformatf("rr%0d m_ready", t), 32'(mr), 32'(2'b01 << exp_g));
                chk($sformatf("rr%0d grant_id", t), 32'(grant_id), 32'(exp_g));
            end
            exp_g = (exp_g == 2'd1) ? 2'd0 : 2'd1;
        end
        @(negedge clk); m_valid = 2'b00; s_ready = 1'b0;

        // First timeout captures err_addr.
        m_valid = 2'b01; m_addr = {32'h0, 32'h0300_0000};
        run_txn(0, 1'b0, bn, mr, rd, ok);
        chk("to1 busy_cycles", 32'(bn), 32'd16);
        chk("to1 m_ready", 32'(mr), 32'h1);
        chk("to1 m_rdata", rd, 32'hDEAD_BEEF);
        @(negedge clk); m_valid = 2'b00; s_ready = 1'b0; #1;
        chk("to1 err_sticky", 32'(err_sticky), 32'h1);
        chk("to1 err_addr", err_addr, 32'h0300_0000);
        chk("to1 m_ready_after", 32'(m_ready), 32'h0);

        // Second timeout leaves err_addr alone; err_clr then clears the flag.
        m_valid = 2'b01; m_addr = {32'h0, 32'h0400_0000};
        run_txn(0, 1'b0, bn, mr, rd, ok);
        chk("to2 m_ready", 32'(mr), 32'h1);
        chk("to2 m_rdata", rd, 32'hDEAD_BEEF);
        @(negedge clk); m_valid = 2'b00; s_ready = 1'b0; #1;
        chk("to2 err_sticky", 32'(err_sticky), 32'h1);
        chk("to2 err_addr", err_addr, 32'h0300_0000);
        err_clr = 1'b1;
        @(negedge clk); err_clr = 1'b0; #1;
        chk("clr err_sticky", 32'(err_sticky), 32'h0);

        // Reset mid-BUSY: rr_ptr is 1 here, so m1 wins first.
        m_valid = 2'b11; m_addr = {32'h0600_0000, 32'h0500_0000};
        @(negedge clk); @(negedge clk); #1;
        chk("rst pre grant_id", 32'(grant_id), 32'h1);
        chk("rst pre s_valid", 32'(s_valid), 32'h1);
        reset = 1'b1; s_ready = 1'b1; #1;
        chk("rst cycle m_ready", 32'(m_ready), 32'h0);
        chk("rst cycle m_rdata", m_rdata, 32'h0);
        @(negedge clk); reset = 1'b0; s_ready = 1'b0; #1;
        chk("rst post s_valid", 32'(s_valid), 32'h0);
        chk("rst post m_ready", 32'(m_ready), 32'h0);
        chk("rst post grant_id", 32'(grant_id), 32'h0);
        @(negedge clk); #1;
        chk("rst first grant", 32'(grant_id), 32'h0);
        chk("rst first s_valid", 32'(s_valid), 32'h1);
        s_ready = 1'b1; s_rdata = 32'h0000_BEEF; #1;
        chk("rst first m_ready", 32'(m_ready), 32'h1);
        @(negedge clk); s_ready = 1'b0; m_valid = 2'b00;

        // Abandon: m1 drops m_valid mid-BUSY; rr_ptr must stay at 1.
        m_valid = 2'b10;
        @(negedge clk); #1;
        chk("ab grant_id", 32'(grant_id), 32'h1);
        chk("ab s_valid", 32'(s_valid), 32'h1);
        m_valid = 2'b00; #1;
        chk("ab drop m_ready", 32'(m_ready), 32'h0);
        @(negedge clk); #1;
        chk("ab s_valid_next", 32'(s_valid), 32'h0);
        chk("ab m_ready_next", 32'(m_ready), 32'h0);
        m_valid = 2'b11;
        @(negedge clk); #1;
        chk("ab next grant", 32'(grant_id), 32'h1);
        s_ready = 1'b1; s_rdata = 32'h0000_1111; #1;
        chk("ab next m_ready", 32'(mr == mr ? m_ready : m_ready), 32'h2);
        chk("ab next m_rdata", m_rdata, 32'h0000_1111);
        @(negedge clk); s_ready = 1'b0; m_valid = 2'b00;

        // err_clr coinciding with a timeout: the timeout wins.
        m_valid = 2'b01; m_addr = {32'h0, 32'h0500_0000};
        run_txn(0, 1'b1, bn, mr, rd, ok);
        chk("tc m_ready", 32'(mr), 32'h1);
        @(negedge clk); err_clr = 1'b0; m_valid = 2'b00; s_ready = 1'b0; #1;
        chk("tc err_sticky", 32'(err_sticky), 32'h1);
        chk("tc err_addr", err_addr, 32'h0500_0000);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1);
    end

endmodule
